mem_log_mc: RTL and testbench
=============================

Name: mem_log_mc

Overview:
- Parametrised successor to the single-channel capture log: records N_CH channels of NB_DATA-bit DSP samples into one on-chip RAM word per sample.
- Adds programmable decimation, one-shot or circular capture mode, a sample-valid qualifier, and write-pointer/wrap reporting for the register file.
- Sits between the dsp block (tx/rx sample taps) and register_file; the MicroBlaze arms the capture and reads it back through GPIO registers.

Parameters:
- NB_DATA, 16, bits per channel sample
- N_CH, 2, number of channels packed per RAM word (word width NB_DATA*N_CH)
- NB_ADDR, 15, address width; depth = 2**NB_ADDR
- NB_DECIM, 8, width of decimation factor

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_data  in  NB_DATA*N_CH  packed samples, channel 0 in LSBs
- i_valid  in  1  sample qualifier
- i_run  in  1  level; rising edge arms capture, falling edge stops circular capture
- i_mode  in  1  0 = one-shot fill, 1 = circular
- i_decim  in  NB_DECIM  keep 1 of (i_decim+1) valid samples
- i_read  in  1  read enable
- i_address  in  NB_ADDR  read address
- o_data  out  NB_DATA*N_CH  read data
- o_data_valid  out  1  o_data updated this cycle
- o_mem_full  out  1  capture finished (one-shot full or circular stopped)
- o_busy  out  1  state is CAPTURE
- o_wrapped  out  1  circular capture wrote past top address at least once
- o_wr_ptr  out  NB_ADDR  next write address (oldest sample once wrapped)

Behaviour:
- Reset: state IDLE; wr_ptr, decim_cnt, o_data, o_data_valid, o_mem_full, o_busy, o_wrapped all 0. RAM contents are not cleared.
- States: IDLE, CAPTURE, DONE.
- Run edge: run_q is registered i_run; rise = i_run & ~run_q.
- IDLE or DONE, rise: go to CAPTURE. Clear wr_ptr, decim_cnt, o_mem_full, o_wrapped. Latch i_mode and i_decim; these are ignored until the next rise.
- CAPTURE, i_valid=1, decim_cnt==0: write i_data at wr_ptr; wr_ptr+1 (modulo 2**NB_ADDR).
- CAPTURE, i_valid=1: decim_cnt increments and wraps to 0 after reaching decim_lat. decim=0 keeps every valid sample.
- CAPTURE, i_valid=0: no write, no count.
- Mode 0: a write at address 2**NB_ADDR-1 moves to DONE with o_mem_full=1 on the next cycle. A falling i_run before that also moves to DONE; o_mem_full=1 and o_wr_ptr gives the sample count.
- Mode 1: the write at the top address wraps wr_ptr to 0 and sets o_wrapped. Falling i_run moves to DONE with o_mem_full=1.
- Simultaneous falling i_run and a qualifying write: the write is performed, then DONE.
- Read: when state≠CAPTURE and i_read=1, o_data = RAM[i_address] and o_data_valid=1 exactly one cycle later (registered RAM output). i_read during CAPTURE is ignored: o_data holds, o_data_valid=0. o_data_valid is 0 whenever no read was accepted the previous cycle.
- DONE holds until rise or rst. rst mid-capture returns to IDLE immediately; partial data stays in RAM but o_mem_full=0.
- o_busy = (state==CAPTURE), registered.

Decomposition:
- Package mem_log_pkg: state encodings (IDLE=0, CAPTURE=1, DONE=2), MODE_ONESHOT=0, MODE_CIRC=1.
- Sub-module log_ram: simple dual-port RAM with 1 write port and 1 registered read port, parametrised width/depth, inferable as BRAM.
- FSM, decimator and pointer logic stay in mem_log_mc.

Test Plan (bench uses NB_ADDR=4, N_CH=2, NB_DATA=16):
- One-shot, decim=0: rise i_run, 16 valid samples {ch1=k, ch0=0x100+k} → o_mem_full=1 the cycle after the 16th write; reading addr 5 gives 0x0005_0105 one cycle later with o_data_valid=1.
- Decimation: decim=2, 48 valid samples k=0..47 → RAM[n]=sample 3n; full after sample 45.
- Gapped valid: i_valid toggling every cycle, decim=0 → only valid samples stored, wr_ptr counts valid samples only.
- Circular: mode=1, 20 samples, then drop i_run → o_wrapped=1, o_wr_ptr=4, RAM[4]=sample 4, RAM[3]=sample 19.
- Read during capture, plus early stop: i_read=1 while busy → o_data_valid=0; one-shot stopped after 7 samples → o_mem_full=1, o_wr_ptr=7.
- Reset mid-capture after 9 samples, then re-arm → all outputs 0 after rst; new capture starts at addr 0 and o_wrapped clears on rise.

Source files
------------

// File: rtl/mem_log_pkg.sv
// Shared encodings for the multi-channel capture log.
package mem_log_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CIRC    = 1'b1;

endpackage

// File: rtl/log_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module log_ram #(
    parameter int WIDTH   = 32,
    parameter int NB_ADDR = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [NB_ADDR-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               re,
    input  logic [NB_ADDR-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem [2**NB_ADDR];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Output register reset only; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else if (re) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_log_mc.sv
// Multi-channel DSP sample capture log with decimation and
// one-shot / circular modes, read back while not capturing.
module mem_log_mc
    import mem_log_pkg::*;
#(
    parameter int NB_DATA  = 16,
    parameter int N_CH     = 2,
    parameter int NB_ADDR  = 15,
    parameter int NB_DECIM = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NB_DATA*N_CH-1:0] i_data,
    input  logic                    i_valid,
    input  logic                    i_run,
    input  logic                    i_mode,
    input  logic [NB_DECIM-1:0]     i_decim,
    input  logic                    i_read,
    input  logic [NB_ADDR-1:0]      i_address,
    output logic [NB_DATA*N_CH-1:0] o_data,
    output logic                    o_data_valid,
    output logic                    o_mem_full,
    output logic                    o_busy,
    output logic                    o_wrapped,
    output logic [NB_ADDR-1:0]      o_wr_ptr
);

    localparam logic [NB_ADDR-1:0]  TOP    = '1;
    localparam logic [NB_ADDR-1:0]  ONE_A  = 1;
    localparam logic [NB_DECIM-1:0] ONE_D  = 1;

    state_t state, state_next;

    logic                run_q;
    logic                rise;
    logic                fall;
    logic                mode_lat;
    logic [NB_DECIM-1:0] decim_lat;
    logic [NB_DECIM-1:0] decim_cnt;
    logic [NB_ADDR-1:0]  wr_ptr;
    logic                we;
    logic                rd_en;
    logic                top_hit;

    assign rise     = i_run & ~run_q;
    assign fall     = ~i_run & run_q;
    assign o_wr_ptr = wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        we         = (state == CAPTURE) && i_valid && (decim_cnt == '0);
        rd_en      = (state != CAPTURE) && i_read;
        top_hit    = we && (wr_ptr == TOP);
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (rise) state_next = CAPTURE;
            end
            CAPTURE: begin
                // A write coinciding with the stop still lands in RAM.
                if (fall || (top_hit && mode_lat == MODE_ONESHOT))
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= 1'b0;
            mode_lat     <= MODE_ONESHOT;
            decim_lat    <= '0;
            decim_cnt    <= '0;
            wr_ptr       <= '0;
            o_mem_full   <= 1'b0;
            o_busy       <= 1'b0;
            o_wrapped    <= 1'b0;
            o_data_valid <= 1'b0;
        end else begin
            run_q        <= i_run;
            o_busy       <= (state_next == CAPTURE);
            o_data_valid <= rd_en;
            if (state != CAPTURE) begin
                if (rise) begin
                    wr_ptr     <= '0;
                    decim_cnt  <= '0;
                    o_mem_full <= 1'b0;
                    o_wrapped  <= 1'b0;
                    mode_lat   <= i_mode;
                    decim_lat  <= i_decim;
                end
            end else begin
                if (i_valid)
                    decim_cnt <= (decim_cnt == decim_lat) ? '0 : decim_cnt + ONE_D;
                if (we)
                    wr_ptr <= wr_ptr + ONE_A;
                if (top_hit && mode_lat == MODE_CIRC)
                    o_wrapped <= 1'b1;
                if (state_next == DONE)
                    o_mem_full <= 1'b1;
            end
        end
    end

    log_ram #(
        .WIDTH   (NB_DATA*N_CH),
        .NB_ADDR (NB_ADDR)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .re      (rd_en),
        .rd_addr (i_address),
        .rd_data (o_data)
    );

endmodule

// File: tb/tb_mem_log_mc.sv
// Bench for mem_log_mc: table of capture scenarios plus
// reset-mid-capture sequence, read data checked via scoreboard queue.
module tb_mem_log_mc;

    localparam int NB_DATA  = 16;
    localparam int N_CH     = 2;
    localparam int NB_ADDR  = 4;
    localparam int NB_DECIM = 8;
    localparam int W        = NB_DATA*N_CH;

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        i_data;
    logic                i_valid;
    logic                i_run;
    logic                i_mode;
    logic [NB_DECIM-1:0] i_decim;
    logic                i_read;
    logic [NB_ADDR-1:0]  i_address;
    logic [W-1:0]        o_data;
    logic                o_data_valid;
    logic                o_mem_full;
    logic                o_busy;
    logic                o_wrapped;
    logic [NB_ADDR-1:0]  o_wr_ptr;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    mem_log_mc #(
        .NB_DATA  (NB_DATA),
        .N_CH     (N_CH),
        .NB_ADDR  (NB_ADDR),
        .NB_DECIM (NB_DECIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_run        (i_run),
        .i_mode       (i_mode),
        .i_decim      (i_decim),
        .i_read       (i_read),
        .i_address    (i_address),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_mem_full   (o_mem_full),
        .o_busy       (o_busy),
        .o_wrapped    (o_wrapped),
        .o_wr_ptr     (o_wr_ptr)
    );

    typedef struct {
        bit mode;
        int decim;
        int nvalid;
        bit gap;
        bit rdbusy;
        int full_at;
        int exp_ptr;
        bit exp_wrap;
        int ra0;
        int rk0;
        int ra1;
        int rk1;
    } vec_t;

    function automatic logic [W-1:0] smp(int k);
        return {16'(k), 16'(256 + k)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (o_data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
                chk("read_data", o_data, sb.pop_front());
            end
        end
    endtask

    task automatic rd(int a, int k);
        i_read    = 1'b1;
        i_address = NB_ADDR'(a);
        sb.push_back(smp(k));
        step();
        i_read = 1'b0;
        chk($sformatf("read_pending_a%0d", a), sb.size(), 0);
        sb.delete();
    endtask

    vec_t v[5];

    initial begin
        v[0] = '{0, 0, 16, 0, 0, 15,  0, 0, 5,  5, 15, 15};
        v[1] = '{0, 2, 48, 0, 0, 45,  0, 0, 7, 21, 15, 45};
        v[2] = '{1, 0, 20, 0, 0, -1,  4, 1, 4,  4,  3, 19};
        v[3] = '{0, 0, 10, 1, 0, -1, 10, 0, 9,  9,  3,  3};
        v[4] = '{0, 0,  7, 0, 1, -1,  7, 0, 6,  6,  0,  0};

        rst = 1'b1; i_data = '0; i_valid = 0; i_run = 0;
        i_mode = 0; i_decim = '0; i_read = 0; i_address = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", o_busy, 0);
        chk("rst_full", o_mem_full, 0);
        chk("rst_wrap", o_wrapped, 0);
        chk("rst_ptr", o_wr_ptr, 0);
        chk("rst_dv", o_data_valid, 0);
        chk("rst_data", o_data, 0);

        for (int i = 0; i < 5; i++) begin
            i_mode  = v[i].mode;
            i_decim = NB_DECIM'(v[i].decim);
            i_run   = 1'b1;
            i_valid = 1'b0;
            step();
            chk($sformatf("v%0d_arm_busy", i), o_busy, 1);
            chk($sformatf("v%0d_arm_wrap", i), o_wrapped, 0);
            chk($sformatf("v%0d_arm_ptr", i), o_wr_ptr, 0);
            chk($sformatf("v%0d_arm_full", i), o_mem_full, 0);
            for (int k = 0; k < v[i].nvalid; k++) begin
                if (v[i].gap) begin
                    i_valid = 1'b0;
                    i_data  = '1;
                    step();
                end
                i_valid = 1'b1;
                i_data  = smp(k);
                i_read  = v[i].rdbusy;
                i_address = 4'd2;
                step();
                if (k == v[i].full_at - 1)
                    chk($sformatf("v%0d_not_full", i), o_mem_full, 0);
                if (k == v[i].full_at)
                    chk($sformatf("v%0d_full_edge", i), o_mem_full, 1);
                if (v[i].rdbusy && k == 3) begin
                    chk($sformatf("v%0d_busy_dv", i), o_data_valid, 0);
                    chk($sformatf("v%0d_busy", i), o_busy, 1);
                end
            end
            i_valid = 1'b0;
            i_read  = 1'b0;
            i_run   = 1'b0;
            step();
            chk($sformatf("v%0d_ptr", i), o_wr_ptr, v[i].exp_ptr);
            chk($sformatf("v%0d_full", i), o_mem_full, 1);
            chk($sformatf("v%0d_wrap", i), o_wrapped, v[i].exp_wrap);
            chk($sformatf("v%0d_idle", i), o_busy, 0);
            rd(v[i].ra0, v[i].rk0);
            rd(v[i].ra1, v[i].rk1);
        end

        // reset in the middle of a capture, then re-arm
        i_mode = 1'b1; i_decim = '0; i_run = 1'b1;
        step();
        for (int k = 0; k < 9; k++) begin
            i_valid = 1'b1;
            i_data  = smp(200 + k);
            step();
        end
        rst = 1'b1; i_valid = 1'b0; i_run = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_full", o_mem_full, 0);
        chk("mid_rst_wrap", o_wrapped, 0);
        chk("mid_rst_ptr", o_wr_ptr, 0);
        chk("mid_rst_dv", o_data_valid, 0);
        chk("mid_rst_data", o_data, 0);

        i_mode = 1'b0; i_run = 1'b1;
        step();
        chk("rearm_ptr", o_wr_ptr, 0);
        chk("rearm_busy", o_busy, 1);
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = smp(50 + k);
            step();
        end
        i_valid = 1'b0; i_run = 1'b0;
        step();
        chk("rearm_stop_ptr", o_wr_ptr, 3);
        chk("rearm_stop_full", o_mem_full, 1);
        rd(0, 50);
        rd(2, 52);
        rd(5, 205);
        step();
        chk("idle_dv", o_data_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
